// File: rtl/serial_arbiter.sv
// serial_arbiter: line-atomic round-robin arbiter sharing one serial transmitter among N_REQ sources
module serial_arbiter #(
  parameter int N_REQ = 2,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_char,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         tx_char,
  output logic               tx_send,
  input  logic               tx_busy,
  output logic [N_REQ-1:0]   grant,
  output logic               timeout
);
  localparam int PW = $clog2(N_REQ);
  localparam int IW = LOCK_TIMEOUT > 1 ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [IW-1:0] IDLE_MAX = LOCK_TIMEOUT == 0 ? {IW{1'b1}} : IW'(LOCK_TIMEOUT - 1);
  typedef enum logic [1:0] {ARB, GRANT, SENT, WAIT} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] rr_q, rr_d, win, idx;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [7:0] tx_char_q, tx_char_d, sel_char;
  logic tx_send_q, tx_send_d, timeout_q, timeout_d, last_q, last_d;
  logic [IW-1:0] idle_q, idle_d;
  logic hit, xfer, sel_valid;
  assign req_ready = (state_q == GRANT && !tx_busy) ? grant_q : '0;
  assign xfer = |(req_valid & req_ready);
  assign sel_valid = |(req_valid & grant_q);
  assign tx_char = tx_char_q;
  assign tx_send = tx_send_q;
  assign grant = grant_q;
  assign timeout = timeout_q;
  // descending scan so the lowest offset from rr is the one left standing
  always_comb begin
    hit = 1'b0;
    win = '0;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = PW'((int'(rr_q) + k) % N_REQ);
      if (req_valid[idx]) begin
        hit = 1'b1;
        win = idx;
      end
    end
  end
  always_comb begin
    sel_char = '0;
    for (int k = 0; k < N_REQ; k++)
      if (grant_q[k]) sel_char = req_char[8*k +: 8];
  end
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    grant_d = grant_q;
    tx_char_d = tx_char_q;
    tx_send_d = 1'b0;
    timeout_d = 1'b0;
    last_d = last_q;
    idle_d = idle_q;
    case (state_q)
      ARB: begin
        grant_d = hit ? N_REQ'(1) << win : '0;
        if (hit) begin
          rr_d = (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
          idle_d = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (xfer) begin
          tx_char_d = sel_char;
          tx_send_d = 1'b1;
          last_d = |(req_last & grant_q);
          idle_d = '0;
          state_d = SENT;
        end else if (!sel_valid) begin
          if (LOCK_TIMEOUT != 0 && idle_q == IDLE_MAX) begin
            grant_d = '0;
            timeout_d = 1'b1;
            state_d = ARB;
          end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + 1'b1;
          end
        end
      end
      // SENT ignores tx_busy because the transmitter raises it one cycle late
      SENT: state_d = WAIT;
      WAIT: begin
        if (!tx_busy) begin
          state_d = last_q ? ARB : GRANT;
          grant_d = last_q ? '0 : grant_q;
        end
      end
      default: state_d = ARB;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB;
      rr_q <= '0;
      grant_q <= '0;
      tx_char_q <= '0;
      tx_send_q <= 1'b0;
      timeout_q <= 1'b0;
      last_q <= 1'b0;
      idle_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      grant_q <= grant_d;
      tx_char_q <= tx_char_d;
      tx_send_q <= tx_send_d;
      timeout_q <= timeout_d;
      last_q <= last_d;
      idle_q <= idle_d;
    end
  end
endmodule
